regfile_write_arbiter: RTL and testbench

Arbitrates two write-back requesters onto the single register-file write port (WE3/A3/WD3) of the RISC-V core. Selection is round-robin with a valid/ready handshake, and the winning write is registered for one cycle. Writes to x0 are accepted but suppressed. Two read paths get a same-cycle bypass so a write in flight is never missed by RD1/RD2 consumers.

---
 rtl/regfile_write_arbiter.sv | 87 ++++++++
 tb/tb_regfile_write_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin write-back arbiter for the register-file write port (WE3/A3/WD3),
// with x0 write suppression and same-cycle read bypass for RD1/RD2.
module regfile_write_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_hold,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_addr,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_addr,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  output logic            WE3,
  output logic [AW-1:0]   A3,
  output logic [XLEN-1:0] WD3,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  input  logic [XLEN-1:0] rd1_in,
  input  logic [XLEN-1:0] rd2_in,
  output logic [XLEN-1:0] rd1_out,
  output logic [XLEN-1:0] rd2_out,
  output logic [15:0]     write_cnt
);

  logic            last_grant;
  logic            grant0;
  logic            grant1;
  logic [AW-1:0]   win_addr;
  logic [XLEN-1:0] win_data;

  // Round-robin grant: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && !wb_hold) begin
      if (req0_valid && (!req1_valid || last_grant)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Winner payload mux.
  always_comb begin
    win_addr = req0_addr;
    win_data = req0_data;
    if (grant1) begin
      win_addr = req1_addr;
      win_data = req1_data;
    end
  end

  // Output stage, grant history and commit counter; x0 writes are accepted but never pulse WE3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      WE3        <= 1'b0;
      A3         <= '0;
      WD3        <= '0;
      write_cnt  <= '0;
    end else if (grant0 || grant1) begin
      last_grant <= grant1;
      A3         <= win_addr;
      WD3        <= win_data;
      WE3        <= (win_addr != '0);
      if (win_addr != '0) begin
        write_cnt <= write_cnt + 16'(1);
      end
    end else begin
      WE3 <= 1'b0;
    end
  end

  // Forward the in-flight write to readers of the same non-zero register.
  assign rd1_out = (WE3 && (A3 == ra1) && (ra1 != '0)) ? WD3 : rd1_in;
  assign rd2_out = (WE3 && (A3 == ra2) && (ra2 != '0)) ? WD3 : rd2_in;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized self-checking bench for regfile_write_arbiter against a behavioural model.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_hold;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1_in, rd2_in, rd1_out, rd2_out;
  logic [15:0] write_cnt;

  regfile_write_arbiter #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .wb_hold(wb_hold),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .ra1(ra1), .ra2(ra2), .rd1_in(rd1_in), .rd2_in(rd2_in),
    .rd1_out(rd1_out), .rd2_out(rd2_out), .write_cnt(write_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: previous winner, pending register-file write, commit count, register contents.
  int          m_prev;
  logic        m_we;
  logic [4:0]  m_a;
  logic [31:0] m_wd;
  int          m_cnt;
  logic [31:0] regs [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_winner();
    if (rst || wb_hold) return -1;
    if (req0_valid && req1_valid) return (m_prev == 0) ? 1 : 0;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] ra, input logic [31:0] raw);
    if (m_we && m_a == ra && ra != 5'd0) return m_wd;
    return raw;
  endfunction

  task automatic model_reset();
    m_prev = 1;
    m_we   = 1'b0;
    m_a    = '0;
    m_wd   = '0;
    m_cnt  = 0;
  endtask

  // One cycle: inputs are already driven; check ready and bypass, clock, then check the write port.
  task automatic step(output int win);
    logic [4:0] wa;
    #1;
    win = model_winner();
    rd1_in = regs[ra1];
    rd2_in = regs[ra2];
    #1;
    check("req0_ready", 32'(req0_ready), 32'(win == 0));
    check("req1_ready", 32'(req1_ready), 32'(win == 1));
    check("rd1_out", rd1_out, model_read(ra1, rd1_in));
    check("rd2_out", rd2_out, model_read(ra2, rd2_in));
    @(posedge clk);
    if (m_we) regs[m_a] = m_wd;
    if (win >= 0) begin
      wa     = (win == 0) ? req0_addr : req1_addr;
      m_prev = win;
      m_a    = wa;
      m_wd   = (win == 0) ? req0_data : req1_data;
      m_we   = (wa != 5'd0);
      if (wa != 5'd0) m_cnt = (m_cnt + 1) % 65536;
    end else begin
      m_we = 1'b0;
    end
    #1;
    check("WE3", 32'(WE3), 32'(m_we));
    check("A3", 32'(A3), 32'(m_a));
    check("WD3", WD3, m_wd);
    check("write_cnt", 32'(write_cnt), 32'(m_cnt));
  endtask

  int w;
  int wins [$];
  logic [31:0] r0d, r1d;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    rst = 1'b1; wb_hold = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
    ra1 = '0; ra2 = '0; rd1_in = '0; rd2_in = '0;
    model_reset();
    #2;
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_we", 32'(WE3), 32'd0);
    check("rst_cnt", 32'(write_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single requester write to x10.
    req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'h1234_5678;
    step(w);
    check("t1_win", 32'(w), 32'd0);
    check("t1_we", 32'(WE3), 32'd1);
    check("t1_a3", 32'(A3), 32'd10);
    check("t1_wd", WD3, 32'h1234_5678);
    check("t1_cnt", 32'(write_cnt), 32'd1);
    req0_valid = 1'b0;

    // Continuous contention alternates winners starting with req1 (req0 won last).
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'd5;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'd4;
    wins.delete();
    repeat (4) begin
      step(w);
      wins.push_back(w);
      check("t2_we", 32'(WE3), 32'd1);
    end
    for (int i = 0; i < 4; i++) check("t2_alt", 32'(wins[i]), 32'(i % 2 == 0 ? 1 : 0));
    check("t2_cnt", 32'(write_cnt), 32'd5);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(w);

    // x0 write accepted, no WE3 pulse, counter unchanged.
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hDEAD_BEEF;
    step(w);
    check("t3_win", 32'(w), 32'd1);
    check("t3_we", 32'(WE3), 32'd0);
    check("t3_cnt", 32'(write_cnt), 32'd5);
    req1_valid = 1'b0;
    // last_grant is now 1, so req0 takes the next tie.
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hCAFE_F00D;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h0000_0099;
    step(w);
    check("t3_tie", 32'(w), 32'd0);
    req0_valid = 1'b0;

    // Bypass while WE3 carries x7.
    ra1 = 5'd7; ra2 = 5'd0;
    #1; regs[7] = 32'd0; rd1_in = 32'd0; rd2_in = 32'd0; #1;
    check("t4_rd1", rd1_out, 32'hCAFE_F00D);
    check("t4_rd2", rd2_out, 32'd0);
    step(w);
    req1_valid = 1'b0;

    // Hold with both valid: nothing granted, in-flight write still pulses once.
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h44;
    wb_hold = 1'b1;
    step(w);
    check("t5_hold0", 32'(w), 32'hFFFF_FFFF);
    step(w);
    step(w);
    check("t5_we", 32'(WE3), 32'd0);
    wb_hold = 1'b0;
    step(w);
    check("t5_rel", 32'(w), 32'd0);
    req0_valid = 1'b0;
    step(w);
    req1_valid = 1'b0;

    // Async reset mid-cycle while WE3 is high.
    req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'hABCD_0001;
    step(w);
    check("t6_pre_we", 32'(WE3), 32'd1);
    #2; rst = 1'b1; #1;
    check("t6_we", 32'(WE3), 32'd0);
    check("t6_a3", 32'(A3), 32'd0);
    check("t6_wd", WD3, 32'd0);
    check("t6_cnt", 32'(write_cnt), 32'd0);
    check("t6_rdy", 32'(req0_ready), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    req1_valid = 1'b1; req1_addr = 5'd13; req1_data = 32'h1313;
    step(w);
    check("t6_tie", 32'(w), 32'd0);
    req0_valid = 1'b0;
    step(w);
    req1_valid = 1'b0;

    // Randomized traffic under the valid/ready protocol.
    for (int c = 0; c < 3000; c++) begin
      if (!req0_valid && $urandom_range(0, 2) != 0) begin
        req0_valid = 1'b1; req0_addr = 5'($urandom_range(0, 7)); r0d = $urandom; req0_data = r0d;
      end
      if (!req1_valid && $urandom_range(0, 2) != 0) begin
        req1_valid = 1'b1; req1_addr = 5'($urandom_range(0, 7)); r1d = $urandom; req1_data = r1d;
      end
      wb_hold = ($urandom_range(0, 7) == 0);
      ra1 = 5'($urandom_range(0, 7));
      ra2 = 5'($urandom_range(0, 7));
      step(w);
      if (w == 0) req0_valid = 1'b0;
      if (w == 1) req1_valid = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; wb_hold = 1'b0;

    // Counter wrap: 65535 commits reach 0xFFFF, the next one wraps to zero.
    rst = 1'b1; #1; rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h1;
    repeat (65535) @(posedge clk);
    #1;
    check("wrap_ffff", 32'(write_cnt), 32'h0000_FFFF);
    @(posedge clk); #1;
    check("wrap_zero", 32'(write_cnt), 32'd0);
    check("wrap_we", 32'(WE3), 32'd1);
    req0_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
